// File: rtl/bridge_status_if.sv
// Bridge status bus: event pulses and raw state in, registered status set out.
// The master modport is the status generator; the slave modport is its event source / status reader.
interface bridge_status_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 cmd_start;
  logic                 cmd_done;
  logic                 err_valid;
  logic [7:0]           err_code;
  logic                 err_clear;
  logic [2:0]           parser_state_i;
  logic [2:0]           bridge_state_i;
  logic                 internal_valid_i;
  logic                 response_ready_i;

  logic                 bridge_busy;
  logic [7:0]           bridge_error;
  logic                 system_ready;
  logic [2:0]           parser_state;
  logic [2:0]           bridge_state;
  logic                 internal_valid;
  logic                 response_ready;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy_timeout;

  modport master (
    input  cmd_start, cmd_done, err_valid, err_code, err_clear,
    input  parser_state_i, bridge_state_i, internal_valid_i, response_ready_i,
    output bridge_busy, bridge_error, system_ready, parser_state, bridge_state,
    output internal_valid, response_ready, err_count, busy_timeout
  );

  modport slave (
    output cmd_start, cmd_done, err_valid, err_code, err_clear,
    output parser_state_i, bridge_state_i, internal_valid_i, response_ready_i,
    input  bridge_busy, bridge_error, system_ready, parser_state, bridge_state,
    input  internal_valid, response_ready, err_count, busy_timeout
  );
endinterface

// File: rtl/bridge_status_gen.sv
// Producer of the bridge status bus: startup delay, busy tracking, sticky error capture, mirrors.
// Define STATUS_TIMEOUT_EN to build the BUSY watchdog (busy_timeout pulse and internal error 0xFE).
module bridge_status_gen #(
  parameter int READY_DELAY  = 16,
  parameter int ERR_CNT_W    = 8,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  bridge_status_if.master  bus
);

  localparam int                DLY_W    = $clog2(READY_DELAY + 1);
  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(READY_DELAY - 1);
  localparam logic [7:0]        TMO_CODE = 8'hFE;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                   input logic [1:0]           inc);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, a} + (ERR_CNT_W+1)'(inc);
    return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
  endfunction

  state_t               state_q, state_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic                 busy_q, ready_q;
  logic [7:0]           err_q, err_d, err_base;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ext_err, int_err;
  logic [2:0]           parser_state_p1, bridge_state_p1;
  logic                 internal_valid_p1, response_ready_p1;

`ifdef STATUS_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(BUSY_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        tmo_hit;
  logic                        tmo_pulse_q;
`endif

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
`ifdef STATUS_TIMEOUT_EN
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        if (dly_q == DLY_LAST) state_d = ST_IDLE;
        else                   dly_d   = dly_q + 1'b1;
      end
      ST_IDLE: begin
`ifdef STATUS_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (bus.cmd_start) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // A done+start pair back-to-back keeps the bridge busy with a fresh command.
        if (bus.cmd_done && !bus.cmd_start) state_d = ST_IDLE;
`ifdef STATUS_TIMEOUT_EN
        if (bus.cmd_done) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          tmo_hit = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef STATUS_TIMEOUT_EN
  assign int_err = tmo_hit;
`else
  assign int_err = 1'b0;
`endif

  // Sticky first-error capture; an external code wins over a simultaneous watchdog error.
  always_comb begin
    ext_err  = bus.err_valid && (bus.err_code != 8'h00);
    err_base = bus.err_clear ? 8'h00 : err_q;
    err_d    = err_base;
    if (err_base == 8'h00) begin
      if (ext_err)      err_d = bus.err_code;
      else if (int_err) err_d = TMO_CODE;
    end
    cnt_d = sat_add(cnt_q, {1'b0, ext_err} + {1'b0, int_err});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_INIT;
      dly_q             <= '0;
      busy_q            <= 1'b0;
      ready_q           <= 1'b0;
      err_q             <= 8'h00;
      cnt_q             <= '0;
      parser_state_p1   <= 3'd0;
      bridge_state_p1   <= 3'd0;
      internal_valid_p1 <= 1'b0;
      response_ready_p1 <= 1'b0;
`ifdef STATUS_TIMEOUT_EN
      tmo_q             <= '0;
      tmo_pulse_q       <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      dly_q             <= dly_d;
      busy_q            <= (state_d == ST_BUSY);
      ready_q           <= (state_d != ST_INIT);
      err_q             <= err_d;
      cnt_q             <= cnt_d;
      parser_state_p1   <= bus.parser_state_i;
      bridge_state_p1   <= bus.bridge_state_i;
      internal_valid_p1 <= bus.internal_valid_i;
      response_ready_p1 <= bus.response_ready_i;
`ifdef STATUS_TIMEOUT_EN
      tmo_q             <= tmo_d;
      tmo_pulse_q       <= tmo_hit;
`endif
    end
  end

  assign bus.bridge_busy    = busy_q;
  assign bus.bridge_error   = err_q;
  assign bus.system_ready   = ready_q;
  assign bus.parser_state   = parser_state_p1;
  assign bus.bridge_state   = bridge_state_p1;
  assign bus.internal_valid = internal_valid_p1;
  assign bus.response_ready = response_ready_p1;
  assign bus.err_count      = cnt_q;
`ifdef STATUS_TIMEOUT_EN
  assign bus.busy_timeout   = tmo_pulse_q;
`else
  assign bus.busy_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_status_gen.sv
// Scoreboard bench for bridge_status_gen: driver pushes predicted status, monitor pops and compares.
module tb_bridge_status_gen;
  localparam int READY_DELAY  = 16;
  localparam int ERR_CNT_W    = 3;
  localparam int BUSY_TIMEOUT = 8;
  localparam int CNT_MAX      = (1 << ERR_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bridge_status_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  bridge_status_gen #(
    .READY_DELAY (READY_DELAY),
    .ERR_CNT_W   (ERR_CNT_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int busy;
    int err;
    int ready;
    int ps;
    int bs;
    int iv;
    int rr;
    int cnt;
    int to;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset, command start time, sticky code, plain integer count.
  int         m_cycles;
  bit         m_busy;
  int         m_busy_since;
  logic [7:0] m_err;
  int         m_cnt;

  task automatic model_step();
    exp_t e;
    bit   was_ready;
    bit   ext;
    bit   tmo;
    if (rst) begin
      m_cycles = 0;
      m_busy   = 0;
      m_err    = 8'h00;
      m_cnt    = 0;
      e = '{default: 0};
    end else begin
      was_ready = (m_cycles >= READY_DELAY);
      m_cycles++;
      tmo = 0;
      if (was_ready) begin
        if (!m_busy) begin
          if (bus.cmd_start) begin
            m_busy = 1;
            m_busy_since = m_cycles;
          end
        end else if (bus.cmd_done) begin
          if (bus.cmd_start) m_busy_since = m_cycles;
          else               m_busy = 0;
        end
`ifdef STATUS_TIMEOUT_EN
        else if (m_cycles - m_busy_since == BUSY_TIMEOUT) begin
          m_busy = 0;
          tmo = 1;
        end
`endif
      end
      ext = bus.err_valid && (bus.err_code != 8'h00);
      if (bus.err_clear) m_err = 8'h00;
      if (m_err == 8'h00) begin
        if (ext)      m_err = bus.err_code;
        else if (tmo) m_err = 8'hFE;
      end
      m_cnt = m_cnt + int'(ext) + int'(tmo);
      if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
      e.busy  = m_busy;
      e.err   = m_err;
      e.ready = (m_cycles >= READY_DELAY);
      e.ps    = bus.parser_state_i;
      e.bs    = bus.bridge_state_i;
      e.iv    = bus.internal_valid_i;
      e.rr    = bus.response_ready_i;
      e.cnt   = m_cnt;
      e.to    = tmo;
    end
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit s, input bit d, input bit v,
                       input logic [7:0] c, input bit cl, input bit rnd_mirror);
    @(negedge clk);
    rst           = r;
    bus.cmd_start = s;
    bus.cmd_done  = d;
    bus.err_valid = v;
    bus.err_code  = c;
    bus.err_clear = cl;
    if (rnd_mirror) begin
      bus.parser_state_i   = 3'($urandom_range(0, 7));
      bus.bridge_state_i   = 3'($urandom_range(0, 7));
      bus.internal_valid_i = 1'($urandom_range(0, 1));
      bus.response_ready_i = 1'($urandom_range(0, 1));
    end else begin
      bus.parser_state_i   = 3'd0;
      bus.bridge_state_i   = 3'd0;
      bus.internal_valid_i = 1'b0;
      bus.response_ready_i = 1'b0;
    end
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bridge_busy",    int'(bus.bridge_busy),    e.busy);
        chk("bridge_error",   int'(bus.bridge_error),   e.err);
        chk("system_ready",   int'(bus.system_ready),   e.ready);
        chk("parser_state",   int'(bus.parser_state),   e.ps);
        chk("bridge_state",   int'(bus.bridge_state),   e.bs);
        chk("internal_valid", int'(bus.internal_valid), e.iv);
        chk("response_ready", int'(bus.response_ready), e.rr);
        chk("err_count",      int'(bus.err_count),      e.cnt);
        chk("busy_timeout",   int'(bus.busy_timeout),   e.to);
      end
    end
  end

  initial begin
    rst                  = 1'b1;
    bus.cmd_start        = 1'b0;
    bus.cmd_done         = 1'b0;
    bus.err_valid        = 1'b0;
    bus.err_code         = 8'h00;
    bus.err_clear        = 1'b0;
    bus.parser_state_i   = 3'd0;
    bus.bridge_state_i   = 3'd0;
    bus.internal_valid_i = 1'b0;
    bus.response_ready_i = 1'b0;

    repeat (3) drive(1, 0, 0, 0, 8'h00, 0, 1);
    idle(20);

    // Command of five cycles.
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    idle(4);
    drive(0, 0, 1, 0, 8'h00, 0, 0);
    idle(3);

    // First error sticks, second only counts, clear leaves the count.
    drive(0, 0, 0, 1, 8'h21, 0, 0);
    drive(0, 0, 0, 1, 8'h33, 0, 0);
    drive(0, 0, 0, 1, 8'h00, 0, 0);
    drive(0, 0, 0, 0, 8'h00, 1, 0);
    idle(2);

    // Count saturation, then clear together with a new error.
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 8'(8'h50 + i), 0, 0);
    drive(0, 0, 0, 1, 8'h44, 1, 0);
    idle(2);
    drive(0, 0, 0, 0, 8'h00, 1, 0);

    // Command never completed: watchdog fires or busy is held.
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    idle(120);
    drive(0, 0, 1, 0, 8'h00, 0, 0);
    idle(3);

    // Reset while busy with an error latched.
    drive(0, 0, 0, 0, 8'h00, 1, 0);
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    drive(0, 0, 0, 1, 8'h10, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 8'h00, 0, 1);
    drive(1, 0, 0, 0, 8'h00, 0, 1);
    idle(20);

    // Randomized traffic including rare resets and zero error codes.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 399) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255))),
            ($urandom_range(0, 15) == 0),
            1);
    end
    idle(2);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
